// File: rtl/bp_update_ctrl_pkg.sv
// Shared predictor geometry, BTB constants and update-FSM state encoding.
package bp_update_ctrl_pkg;
  localparam int WORD_SIZE  = 16;
  localparam int BP_INDEX_W = 8;
  localparam int BP_TAG_W   = WORD_SIZE - BP_INDEX_W;

  localparam logic [15:0] BTB_INVALID = 16'hFFFF;

  typedef enum logic [1:0] {
    BP_ST_INIT = 2'd0,
    BP_ST_IDLE = 2'd1,
    BP_ST_RD   = 2'd2,
    BP_ST_WR   = 2'd3
  } bp_state_e;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return nxt;
  endfunction
endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO holding resolved-branch records until the table port is free.
module bp_update_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [WIDTH-1:0]       head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_LEVEL);
  assign empty     = (count_r == '0);
  assign level     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + LVL_ONE;
        2'b01:   count_r <= count_r - LVL_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Record storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end
endmodule

// File: rtl/bp_update_ctrl.sv
// Branch predictor update sequencer: init sweep, mispredict flagging and
// queued two-cycle read-modify-write into the BTB/counter tables.
module bp_update_ctrl #(
  parameter int WORD_SIZE  = bp_update_ctrl_pkg::WORD_SIZE,
  parameter int INDEX_W    = bp_update_ctrl_pkg::BP_INDEX_W,
  parameter int TAG_W      = WORD_SIZE - INDEX_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [WORD_SIZE-1:0] res_pc,
  input  logic                 res_taken,
  input  logic [WORD_SIZE-1:0] res_target,
  input  logic [WORD_SIZE-1:0] res_pred_pc,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [INDEX_W-1:0]   tbl_rd_index,
  input  logic [1:0]           tbl_rd_cnt,
  output logic                 tbl_we,
  output logic [INDEX_W-1:0]   tbl_index,
  output logic [TAG_W-1:0]     tbl_tag,
  output logic [WORD_SIZE-1:0] tbl_target,
  output logic [1:0]           tbl_cnt,
  output logic                 init_done
);
  import bp_update_ctrl_pkg::*;

  localparam int REC_W = 2 * WORD_SIZE + 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]     LVL_ONE     = LVL_W'(1);
  localparam logic [INDEX_W-1:0]   SWEEP_LAST  = {INDEX_W{1'b1}};
  localparam logic [INDEX_W-1:0]   SWEEP_ONE   = INDEX_W'(1);
  localparam logic [WORD_SIZE-1:0] PC_ONE      = WORD_SIZE'(1);
  localparam logic [WORD_SIZE-1:0] INVALID_TGT = WORD_SIZE'(BTB_INVALID);

  bp_state_e            state_r, state_s;
  logic [INDEX_W-1:0]   sweep_r, sweep_s;
  logic                 init_done_r, init_done_s;
  logic                 tbl_we_r, tbl_we_s;
  logic [INDEX_W-1:0]   tbl_index_r, tbl_index_s;
  logic [TAG_W-1:0]     tbl_tag_r, tbl_tag_s;
  logic [WORD_SIZE-1:0] tbl_target_r, tbl_target_s;
  logic [1:0]           tbl_cnt_r, tbl_cnt_s;
  logic                 mispredict_r;
  logic [WORD_SIZE-1:0] redirect_pc_r;

  logic                 push_s, pop_s, full_s, empty_s;
  logic [LVL_W-1:0]     level_s;
  logic [REC_W-1:0]     push_rec_s, head_rec_s;
  logic [WORD_SIZE-1:0] head_pc_s, head_target_s, correct_pc_s;
  logic                 head_taken_s;

  assign res_ready    = init_done_r && !full_s;
  assign push_s       = res_valid && res_ready;
  assign push_rec_s   = {res_pc, res_taken, res_target};
  assign {head_pc_s, head_taken_s, head_target_s} = head_rec_s;
  assign correct_pc_s = res_taken ? res_target : res_pc + PC_ONE;
  assign tbl_rd_index = head_pc_s[INDEX_W-1:0];

  assign mispredict  = mispredict_r;
  assign redirect_pc = redirect_pc_r;
  assign tbl_we      = tbl_we_r;
  assign tbl_index   = tbl_index_r;
  assign tbl_tag     = tbl_tag_r;
  assign tbl_target  = tbl_target_r;
  assign tbl_cnt     = tbl_cnt_r;
  assign init_done   = init_done_r;

  bp_update_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_rec_s),
    .pop       (pop_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s),
    .head      (head_rec_s)
  );

  // Next state; the write port is loaded one cycle ahead so the RMW write lands during WR.
  always_comb begin
    state_s      = state_r;
    sweep_s      = sweep_r;
    init_done_s  = init_done_r;
    tbl_we_s     = 1'b0;
    tbl_index_s  = '0;
    tbl_tag_s    = '0;
    tbl_target_s = '0;
    tbl_cnt_s    = 2'b00;
    pop_s        = 1'b0;
    case (state_r)
      BP_ST_INIT: begin
        tbl_we_s     = 1'b1;
        tbl_index_s  = sweep_r;
        tbl_target_s = INVALID_TGT;
        sweep_s      = sweep_r + SWEEP_ONE;
        if (sweep_r == SWEEP_LAST) begin
          state_s     = BP_ST_IDLE;
          init_done_s = 1'b1;
        end else begin
          state_s = BP_ST_INIT;
        end
      end
      BP_ST_IDLE: begin
        if (!empty_s) begin
          state_s = BP_ST_RD;
        end else begin
          state_s = BP_ST_IDLE;
        end
      end
      BP_ST_RD: begin
        tbl_we_s     = 1'b1;
        tbl_index_s  = head_pc_s[INDEX_W-1:0];
        tbl_tag_s    = head_pc_s[WORD_SIZE-1:INDEX_W];
        tbl_target_s = head_target_s;
        tbl_cnt_s    = sat_cnt_next(tbl_rd_cnt, head_taken_s);
        state_s      = BP_ST_WR;
      end
      BP_ST_WR: begin
        pop_s = 1'b1;
        if ((level_s > LVL_ONE) || push_s) begin
          state_s = BP_ST_RD;
        end else begin
          state_s = BP_ST_IDLE;
        end
      end
      default: state_s = BP_ST_INIT;
    endcase
  end

  // FSM, sweep pointer and registered table write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= BP_ST_INIT;
      sweep_r      <= '0;
      init_done_r  <= 1'b0;
      tbl_we_r     <= 1'b0;
      tbl_index_r  <= '0;
      tbl_tag_r    <= '0;
      tbl_target_r <= '0;
      tbl_cnt_r    <= 2'b00;
    end else begin
      state_r      <= state_s;
      sweep_r      <= sweep_s;
      init_done_r  <= init_done_s;
      tbl_we_r     <= tbl_we_s;
      tbl_index_r  <= tbl_index_s;
      tbl_tag_r    <= tbl_tag_s;
      tbl_target_r <= tbl_target_s;
      tbl_cnt_r    <= tbl_cnt_s;
    end
  end

  // Mispredict check runs on accept, independent of drain progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispredict_r  <= 1'b0;
      redirect_pc_r <= '0;
    end else if (push_s) begin
      mispredict_r  <= (correct_pc_s != res_pred_pc);
      redirect_pc_r <= correct_pc_s;
    end else begin
      mispredict_r  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a table model and a write scoreboard.
module tb_bp_update_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        res_valid, res_ready, res_taken;
  logic [15:0] res_pc, res_target, res_pred_pc;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [7:0]  tbl_rd_index;
  logic [1:0]  tbl_rd_cnt;
  logic        tbl_we;
  logic [7:0]  tbl_index, tbl_tag;
  logic [15:0] tbl_target;
  logic [1:0]  tbl_cnt;
  logic        init_done;

  typedef struct packed {
    logic [7:0]  idx;
    logic [7:0]  tag;
    logic [15:0] target;
    logic [1:0]  cnt;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          saw_stall = 1'b0;
  int          wr_cyc[$];
  wr_t         exp_q[$];
  logic [1:0]  shadow [256];
  logic [15:0] exp_redirect;
  logic [1:0]  tbl_model [256];

  always #5 clk = ~clk;

  bp_update_ctrl #(.WORD_SIZE(16), .INDEX_W(8), .TAG_W(8), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_pc       (res_pc),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .res_pred_pc  (res_pred_pc),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .tbl_rd_index (tbl_rd_index),
    .tbl_rd_cnt   (tbl_rd_cnt),
    .tbl_we       (tbl_we),
    .tbl_index    (tbl_index),
    .tbl_tag      (tbl_tag),
    .tbl_target   (tbl_target),
    .tbl_cnt      (tbl_cnt),
    .init_done    (init_done)
  );

  // Counter table model with combinational read.
  always @(posedge clk) if (tbl_we) tbl_model[tbl_index] <= tbl_cnt;
  assign tbl_rd_cnt = tbl_model[tbl_rd_index];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [1:0] model_sat(input logic [1:0] c, input logic t);
    int v;
    v = t ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  function automatic logic [63:0] rst_vec();
    return 64'({mispredict, redirect_pc, tbl_we, tbl_index, tbl_tag, tbl_target, tbl_cnt, init_done, res_ready});
  endfunction

  function automatic logic [63:0] sweep_vec();
    return 64'({tbl_we, tbl_index, tbl_tag, tbl_target, tbl_cnt, init_done, res_ready});
  endfunction

  // One clock; outputs sampled 1 time unit after the edge, writes scored against the queue.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en && tbl_we) begin
      chk("write_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_entry", 64'({tbl_index, tbl_tag, tbl_target, tbl_cnt}), 64'(e));
        wr_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic check_sweep(input int n);
    logic [63:0] want;
    chk("sweep_start", sweep_vec(), 64'd0);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k <= 256) want = 64'({1'b1, 8'(k - 1), 8'h00, 16'hFFFF, 2'b00, k == 256, k == 256});
      else          want = 64'({1'b0, 8'h00, 8'h00, 16'h0000, 2'b00, 1'b1, 1'b1});
      chk($sformatf("sweep_%0d", k), sweep_vec(), want);
    end
  endtask

  task automatic send(input logic [15:0] pc, input logic tk, input logic [15:0] tgt, input logic [15:0] pred);
    logic [15:0] cpc;
    logic [7:0]  idx;
    bit          done;
    int          tries;
    res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt; res_pred_pc = pred;
    cpc = tk ? tgt : pc + 16'd1;
    idx = pc[7:0];
    done = 1'b0;
    tries = 0;
    while (!done && tries < 50) begin
      if (res_ready) begin
        shadow[idx] = model_sat(shadow[idx], tk);
        exp_q.push_back('{idx: idx, tag: pc[15:8], target: tgt, cnt: shadow[idx]});
        step();
        exp_redirect = cpc;
        chk("mispredict_redirect", 64'({mispredict, redirect_pc}), 64'({cpc != pred, cpc}));
        done = 1'b1;
      end else begin
        saw_stall = 1'b1;
        step();
        chk("stall_hold", 64'({mispredict, redirect_pc}), 64'({1'b0, exp_redirect}));
        tries++;
      end
    end
    chk("accept_in_time", 64'(done), 64'd1);
  endtask

  task automatic idle_check();
    res_valid = 1'b0;
    step();
    chk("idle_hold", 64'({mispredict, redirect_pc}), 64'({1'b0, exp_redirect}));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    res_valid = 1'b0;
    while (exp_q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    chk("drain_complete", 64'(exp_q.size()), 64'd0);
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; res_valid = 1'b0; res_pc = 16'h0000; res_taken = 1'b0;
    res_target = 16'h0000; res_pred_pc = 16'h0000; exp_redirect = 16'h0000;
    for (int i = 0; i < 256; i++) shadow[i] = 2'b00;
    step(); step();
    chk("reset_outputs", rst_vec(), 64'd0);
    reset_n = 1'b1;
    check_sweep(260);
    mon_en = 1'b1;

    send(16'h0012, 1'b1, 16'h0020, 16'h0013); idle_check(); wait_drain();
    send(16'h0312, 1'b1, 16'h0320, 16'h0313); idle_check(); wait_drain();
    send(16'h0050, 1'b0, 16'h0060, 16'h0051); idle_check(); wait_drain();
    for (int k = 0; k < 4; k++) send(16'(k << 8) | 16'h0070, 1'b1, 16'h0100, 16'h0100);
    idle_check(); wait_drain();
    send(16'h0080, 1'b0, 16'h0090, 16'h0090);
    send(16'hFFFF, 1'b0, 16'h1234, 16'h0000);
    idle_check(); wait_drain();

    send(16'h0140, 1'b1, 16'h0200, 16'h0200); wait_drain();
    send(16'h0240, 1'b1, 16'h0300, 16'h0241);
    send(16'h0340, 1'b1, 16'h0400, 16'h0400);
    idle_check(); wait_drain();

    saw_stall = 1'b0;
    wr_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      logic [15:0] pc;
      pc = 16'h1000 + 16'(k * 17);
      send(pc, (k % 2) == 1, pc + 16'h0020, (k % 3 == 0) ? pc + 16'd1 : pc + 16'h0020);
    end
    idle_check(); wait_drain();
    chk("burst_stall_seen", 64'(saw_stall), 64'd1);
    chk("burst_write_count", 64'(wr_cyc.size()), 64'd8);
    for (int k = 1; k < wr_cyc.size(); k++) chk("burst_spacing", 64'(wr_cyc[k] - wr_cyc[k - 1]), 64'd2);

    send(16'h0021, 1'b1, 16'h0500, 16'h0500);
    send(16'h0022, 1'b1, 16'h0500, 16'h0500);
    send(16'h0023, 1'b1, 16'h0600, 16'h0024);
    res_valid = 1'b0; mon_en = 1'b0; exp_q.delete();
    reset_n = 1'b0;
    #1;
    chk("reset_mid_drain", rst_vec(), 64'd0);
    step(); step();
    chk("reset_mid_drain_held", rst_vec(), 64'd0);
    reset_n = 1'b1;
    check_sweep(101);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_sweep", rst_vec(), 64'd0);
    step(); step();
    reset_n = 1'b1;
    exp_redirect = 16'h0000;
    for (int i = 0; i < 256; i++) shadow[i] = 2'b00;
    check_sweep(260);
    mon_en = 1'b1;
    send(16'h0312, 1'b1, 16'h0320, 16'h0313); idle_check(); wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
